// File: rtl/audio_voice_scheduler.sv
// Audio voice scheduler: polls each voice round-robin for one signed sample,
// mixes the samples, attenuates the sum and writes one left-justified stereo
// frame into the audio output FIFO.
module audio_voice_scheduler #(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = 7,
  parameter int TIMEOUT    = 16
) (
  input  logic                           CLOCK_50,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic [NUM_VOICES-1:0]          voice_mask,
  input  logic [2:0]                     master_shift,
  output logic [NUM_VOICES-1:0]          voice_req,
  input  logic [NUM_VOICES-1:0]          voice_ack,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_data,
  input  logic                           audio_out_allowed,
  output logic                           write_audio_out,
  output logic [31:0]                    left_channel_audio_out,
  output logic [31:0]                    right_channel_audio_out,
  output logic                           frame_done,
  output logic [NUM_VOICES-1:0]          voice_timeout,
  output logic [1:0]                     dbg_state
);

  localparam int ACC_W  = SAMPLE_W + $clog2(NUM_VOICES);
  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int TCNT_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_VOICES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT_OUT, WRITE} state_t;

  state_t                     state, state_n;
  logic [IDX_W-1:0]           idx, idx_n;
  logic signed [ACC_W-1:0]    acc, acc_n;
  logic [TCNT_W-1:0]          tcnt, tcnt_n;
  logic [NUM_VOICES-1:0]      req, req_n;
  logic [NUM_VOICES-1:0]      tmo, tmo_n;
  logic                       voice_done;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [SAMPLE_W-1:0] samples [NUM_VOICES];

  // Unpack the flat voice data bus into one signed sample per voice.
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_unpack
    assign samples[g] = voice_data[g*SAMPLE_W +: SAMPLE_W];
  end

  // Attenuated mix of the accumulator value that will be current in WRITE.
  assign shifted = acc_n >>> master_shift;

  assign voice_req     = req;
  assign voice_timeout = tmo;
  assign dbg_state     = state;

  // Voice handshake: the scheduler raises voice_req[i] (one-hot) and holds it
  // until the first posedge where voice_ack[i] is sampled high; that edge
  // transfers voice_data[i] and req drops after it. Acks on any bit that is
  // not currently requested are ignored. A voice that leaves req high for
  // TIMEOUT cycles is skipped and contributes zero.

  // Next-state, accumulator, request and timeout logic.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    acc_n      = acc;
    tcnt_n     = tcnt;
    req_n      = req;
    tmo_n      = tmo;
    voice_done = 1'b0;
    case (state)
      IDLE: begin
        if (enable && audio_out_allowed) begin
          acc_n   = '0;
          idx_n   = '0;
          tcnt_n  = '0;
          state_n = FETCH;
        end
      end
      FETCH: begin
        if (req == '0) begin
          // Mask is looked at live, only when this voice's turn begins.
          if (voice_mask[idx]) begin
            req_n  = NUM_VOICES'(1) << idx;
            tcnt_n = '0;
          end else begin
            voice_done = 1'b1;
          end
        end else if (voice_ack[idx]) begin
          // An ack in the final timeout cycle still wins.
          acc_n      = acc + ACC_W'(samples[idx]);
          req_n      = '0;
          voice_done = 1'b1;
        end else if (tcnt == TCNT_LAST) begin
          tmo_n[idx] = 1'b1;
          req_n      = '0;
          voice_done = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
        if (voice_done) begin
          if (idx == LAST_IDX) begin
            state_n = audio_out_allowed ? WRITE : WAIT_OUT;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      WAIT_OUT: begin
        if (audio_out_allowed) begin
          state_n = WRITE;
        end
      end
      WRITE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; the output word and strobes are
  // loaded on the edge that enters WRITE so they are valid during WRITE.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state                   <= IDLE;
      idx                     <= '0;
      acc                     <= '0;
      tcnt                    <= '0;
      req                     <= '0;
      tmo                     <= '0;
      write_audio_out         <= 1'b0;
      frame_done              <= 1'b0;
      left_channel_audio_out  <= '0;
      right_channel_audio_out <= '0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      acc             <= acc_n;
      tcnt            <= tcnt_n;
      req             <= req_n;
      tmo             <= tmo_n;
      write_audio_out <= (state_n == WRITE);
      frame_done      <= (state_n == WRITE);
      if (state_n == WRITE) begin
        left_channel_audio_out  <= {shifted, {(32-ACC_W){1'b0}}};
        right_channel_audio_out <= {shifted, {(32-ACC_W){1'b0}}};
      end
    end
  end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Testbench for audio_voice_scheduler: behavioural voice responders, a
// frame-level mixing model and directed plus randomized frames.
module tb_audio_voice_scheduler;

  localparam int NV = 4;
  localparam int SW = 7;
  localparam int TO = 16;

  // ---------------- clock / reset / signals ----------------
  logic             CLOCK_50 = 1'b0;
  logic             resetn = 1'b1;
  logic             enable = 1'b0;
  logic [NV-1:0]    voice_mask = '0;
  logic [2:0]       master_shift = '0;
  logic [NV-1:0]    voice_req;
  logic [NV-1:0]    voice_ack = '0;
  logic [NV*SW-1:0] voice_data = '0;
  logic             audio_out_allowed = 1'b0;
  logic             write_audio_out;
  logic [31:0]      left_out, right_out;
  logic             frame_done;
  logic [NV-1:0]    voice_timeout;
  logic [1:0]       dbg_state;

  always #10 CLOCK_50 = ~CLOCK_50;

  audio_voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .TIMEOUT(TO)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .enable(enable),
    .voice_mask(voice_mask), .master_shift(master_shift),
    .voice_req(voice_req), .voice_ack(voice_ack), .voice_data(voice_data),
    .audio_out_allowed(audio_out_allowed), .write_audio_out(write_audio_out),
    .left_channel_audio_out(left_out), .right_channel_audio_out(right_out),
    .frame_done(frame_done), .voice_timeout(voice_timeout), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [NV-1:0] tmo_model = '0;

  int data_v[NV];
  int lat[NV];          // req-high cycles a voice waits before acking
  int hold[NV];
  int req_cycles[NV];
  int first_req = -1;
  int onehot_bad = 0, fd_bad = 0, b2b_bad = 0, writes = 0;
  bit noise_en = 1'b0;
  logic prev_wr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  // Voice responders plus protocol monitor, all away from the active edge.
  always @(negedge CLOCK_50) begin
    for (int i = 0; i < NV; i++) begin
      if (voice_req[i]) begin
        voice_ack[i] = (hold[i] >= lat[i]);
        hold[i]++;
        req_cycles[i]++;
        if (first_req < 0) first_req = i;
      end else begin
        hold[i] = 0;
        voice_ack[i] = noise_en && ($urandom_range(0, 1) == 1);
      end
    end
    if (voice_req != '0 && (voice_req & (voice_req - 1'b1)) != '0) onehot_bad++;
    if (write_audio_out !== frame_done) fd_bad++;
    if (write_audio_out && prev_wr) b2b_bad++;
    if (write_audio_out) writes++;
    prev_wr = write_audio_out;
  end

  // ---------------- driver tasks ----------------
  task automatic load_voices();
    for (int i = 0; i < NV; i++) begin
      voice_data[i*SW +: SW] = SW'(data_v[i]);
      req_cycles[i] = 0;
    end
    first_req = -1;
  endtask

  task automatic run_frame(input logic [NV-1:0] m, input logic [2:0] sh,
                           input string tag, input bit stall);
    int sum, s, wr0, got, lowest;
    logic [31:0] e;
    @(negedge CLOCK_50);
    voice_mask = m;
    master_shift = sh;
    load_voices();
    wr0 = writes;
    // model: a masked-in voice contributes if it acks within TIMEOUT req cycles
    sum = 0;
    lowest = -1;
    for (int i = 0; i < NV; i++) begin
      if (m[i]) begin
        if (lowest < 0) lowest = i;
        if (lat[i] <= TO - 1) sum += data_v[i];
        else tmo_model[i] = 1'b1;
      end
    end
    s = floor_div(sum, 1 << sh);
    e = 32'(s * (1 << 23));
    exp_q.push_back(e);
    enable = 1'b1;
    audio_out_allowed = 1'b1;
    @(negedge CLOCK_50);
    enable = 1'b0;
    got = 0;
    if (stall) begin
      audio_out_allowed = 1'b0;
      repeat (100) @(negedge CLOCK_50);
      chk({tag, "_stall_no_strobe"}, writes - wr0, 0);
      audio_out_allowed = 1'b1;
      @(posedge CLOCK_50); #1;
      got = int'(write_audio_out);
      chk({tag, "_stall_strobe"}, got, 1);
    end else begin
      for (int c = 0; c < 200 && got == 0; c++) begin
        @(posedge CLOCK_50); #1;
        if (write_audio_out) got = 1;
      end
      chk({tag, "_write_seen"}, got, 1);
    end
    e = exp_q.pop_front();
    chk({tag, "_left"}, left_out, e);
    chk({tag, "_right"}, right_out, e);
    chk({tag, "_frame_done"}, frame_done, 1);
    chk({tag, "_timeout"}, voice_timeout, tmo_model);
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("%s_req_cycles%0d", tag, i), req_cycles[i],
          !m[i] ? 0 : (lat[i] <= TO - 1 ? lat[i] + 1 : TO));
    end
    chk({tag, "_first_req"}, first_req, lowest);
    repeat (3) @(negedge CLOCK_50);
    chk({tag, "_hold_left"}, left_out, e);
    chk({tag, "_single_write"}, writes - wr0, 1);
    chk({tag, "_onehot"}, onehot_bad, 0);
    chk({tag, "_done_eq_write"}, fd_bad, 0);
    chk({tag, "_no_b2b"}, b2b_bad, 0);
  endtask

  task automatic set_voices(input int d0, d1, d2, d3, input int l0, l1, l2, l3);
    data_v[0] = d0; data_v[1] = d1; data_v[2] = d2; data_v[3] = d3;
    lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int wr0, got;
    set_voices(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NV; i++) hold[i] = 0;
    #1 resetn = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_req", voice_req, 0);
    chk("rst_write", write_audio_out, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_left", left_out, 0);
    chk("rst_right", right_out, 0);
    chk("rst_timeout", voice_timeout, 0);
    chk("rst_state_idle", dbg_state, 0);
    resetn = 1'b1;

    // enable without FIFO space must not start a frame
    @(negedge CLOCK_50);
    enable = 1'b1;
    audio_out_allowed = 1'b0;
    repeat (5) @(negedge CLOCK_50);
    chk("no_start_req", voice_req, 0);
    enable = 1'b0;

    set_voices(10, 20, -5, 0, 0, 0, 0, 0);
    run_frame(4'b1111, 3'd0, "t1", 1'b0);
    chk("t1_const", left_out, 32'h0C80_0000);

    set_voices(-64, -64, -64, -64, 0, 0, 0, 0);
    run_frame(4'b1111, 3'd0, "t2neg", 1'b0);
    chk("t2neg_const", left_out, 32'h8000_0000);
    set_voices(63, 63, 63, 63, 0, 0, 0, 0);
    run_frame(4'b1111, 3'd0, "t2pos", 1'b0);
    chk("t2pos_const", left_out, 32'h7E00_0000);

    // voice 2 never acks; voice 0 acks on the last allowed cycle
    set_voices(5, 6, 40, 7, 15, 1, 100, 2);
    run_frame(4'b1111, 3'd0, "t3", 1'b0);
    chk("t3_timeout_const", voice_timeout, 4'b0100);

    set_voices(9, -3, 12, 1, 0, 2, 1, 0);
    run_frame(4'b1111, 3'd2, "t4", 1'b1);

    set_voices(25, 17, -51, 33, 0, 0, 0, 0);
    run_frame(4'b0101, 3'd1, "t5", 1'b0);
    chk("t5_const", left_out, 32'hF980_0000);
    run_frame(4'b0000, 3'd0, "t5zero", 1'b0);
    chk("t5zero_const", left_out, 32'h0000_0000);

    // reset while voice 1 is being requested
    set_voices(1, 2, 3, 4, 0, 10, 0, 0);
    @(negedge CLOCK_50);
    voice_mask = 4'b1111;
    load_voices();
    wr0 = writes;
    enable = 1'b1;
    audio_out_allowed = 1'b1;
    @(negedge CLOCK_50);
    enable = 1'b0;
    got = 0;
    for (int c = 0; c < 50 && got == 0; c++) begin
      @(posedge CLOCK_50); #1;
      if (voice_req[1]) got = 1;
    end
    chk("t6_req1_seen", got, 1);
    resetn = 1'b0;
    tmo_model = '0;
    #1;
    chk("t6_req", voice_req, 0);
    chk("t6_write", write_audio_out, 0);
    chk("t6_done", frame_done, 0);
    chk("t6_left", left_out, 0);
    chk("t6_right", right_out, 0);
    chk("t6_timeout", voice_timeout, 0);
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    chk("t6_no_write", writes - wr0, 0);
    set_voices(-7, 8, 9, -10, 1, 0, 3, 0);
    run_frame(4'b1111, 3'd0, "t6post", 1'b0);

    // randomized frames with ack noise on idle voices
    noise_en = 1'b1;
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NV; i++) begin
        data_v[i] = int'($urandom_range(0, 127)) - 64;
        lat[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(14, 20))
                                              : int'($urandom_range(0, 4));
      end
      run_frame(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                $sformatf("rnd%0d", f), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
